// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: issues one level req/ack transaction per
// load/store, stalls the pipeline until it completes, and flags timeouts.
module mem_access_ctrl #(
    parameter int unsigned WAIT_MAX = 64,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             MemRead_i,
    input  logic             MemWrite_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      wdata_i,
    input  logic             mem_ack_i,
    input  logic [31:0]      mem_rdata_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic             stall_o,
    output logic [31:0]      rdata_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_e           state_q, state_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             access;
    logic             stall;

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        wait_d      = wait_q;
        stall_cnt_d = stall_cnt_q;
        access      = MemRead_i | MemWrite_i;
        stall       = 1'b0;

        case (state_q)
            IDLE: begin
                // Stall is raised combinationally so the pipeline holds at this very edge.
                stall = access;
                if (access) begin
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    we_d    = MemWrite_i;
                    wait_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall  = 1'b1;
                wait_d = wait_q + 8'd1;
                if (mem_ack_i) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata_i;
                    end
                    state_d = DONE;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            wait_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Reset must drop stall immediately even if a load/store is still presented.
    assign stall_o     = stall & ~rst_i;
    assign mem_req_o   = (state_q == BUSY);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;
    assign stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: expected results are queued per access
// and compared when the controller reaches DONE.
module tb_mem_access_ctrl;
    localparam int unsigned WMAX = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i, MemWrite_i, mem_ack_i;
    logic [31:0] addr_i, wdata_i, mem_rdata_i;
    logic        mem_req_o, mem_we_o, stall_o, err_o;
    logic [31:0] mem_addr_o, mem_wdata_o, rdata_o, stall_cnt_o;
    logic        s_req, s_we, s_stall, s_err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [2:0]  s_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          stalls;
        int          busy;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_rdata;
    logic        m_err;
    int          m_cnt;

    always #5 clk_i = ~clk_i;

    mem_access_ctrl #(.WAIT_MAX(WMAX), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .stall_o(stall_o), .rdata_o(rdata_o), .err_o(err_o),
        .stall_cnt_o(stall_cnt_o)
    );

    // Narrow counter instance to exercise saturation.
    mem_access_ctrl #(.WAIT_MAX(WMAX), .CNT_W(3)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .mem_req_o(s_req), .mem_we_o(s_we), .mem_addr_o(s_addr), .mem_wdata_o(s_wdata),
        .stall_o(s_stall), .rdata_o(s_rdata), .err_o(s_err), .stall_cnt_o(s_cnt)
    );

    // ack_at = BUSY cycle (1-based) in which memory acks; 0 = never ack.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd_data,
                             input int ack_at, input string name);
        exp_t e;
        exp_t g;
        int   stalls;
        int   busy;
        int   cyc;
        e.we    = wr;
        e.addr  = a;
        e.wdata = wd;
        if (ack_at == 0) begin
            e.err   = 1'b1;
            e.rdata = '0;
            e.busy  = WMAX;
        end else begin
            e.err   = m_err;
            e.rdata = wr ? m_rdata : rd_data;
            e.busy  = ack_at;
        end
        e.stalls = e.busy + 1;
        sb.push_back(e);
        m_rdata = e.rdata;
        m_err   = e.err;
        m_cnt   = m_cnt + e.stalls;

        MemRead_i  = rd;
        MemWrite_i = wr;
        addr_i     = a;
        wdata_i    = wd;
        stalls = 0;
        busy   = 0;
        cyc    = 0;
        #1;
        while (stall_o && cyc < 100) begin
            stalls++;
            cyc++;
            if (mem_req_o) begin
                busy++;
                checks++;
                if (mem_we_o !== wr || mem_addr_o !== a || mem_wdata_o !== wd) begin
                    failures++;
                    $display("FAIL %s_req_stable: got we=%b addr=%h wdata=%h, want we=%b addr=%h wdata=%h",
                             name, mem_we_o, mem_addr_o, mem_wdata_o, wr, a, wd);
                end
                mem_ack_i   = (busy == ack_at);
                mem_rdata_i = (busy == ack_at) ? rd_data : 32'hBAD0_BAD0;
            end
            @(negedge clk_i);
            #1;
        end
        mem_ack_i = 1'b0;

        g = sb.pop_front();
        checks++;
        if (cyc >= 100) begin
            failures++;
            $display("FAIL %s_hang: stall still %b after %0d cycles, want release", name, stall_o, cyc);
        end
        checks++;
        if (stalls !== g.stalls) begin
            failures++;
            $display("FAIL %s_stalls: got %0d, want %0d", name, stalls, g.stalls);
        end
        checks++;
        if (busy !== g.busy) begin
            failures++;
            $display("FAIL %s_req_cycles: got %0d, want %0d", name, busy, g.busy);
        end
        checks++;
        if (mem_req_o !== 1'b0 || mem_we_o !== g.we) begin
            failures++;
            $display("FAIL %s_done_req: got req=%b we=%b, want req=0 we=%b", name, mem_req_o, mem_we_o, g.we);
        end
        checks++;
        if (rdata_o !== g.rdata) begin
            failures++;
            $display("FAIL %s_rdata: got %h, want %h", name, rdata_o, g.rdata);
        end
        checks++;
        if (err_o !== g.err) begin
            failures++;
            $display("FAIL %s_err: got %b, want %b", name, err_o, g.err);
        end
        checks++;
        if (stall_cnt_o !== 32'(m_cnt)) begin
            failures++;
            $display("FAIL %s_stall_cnt: got %0d, want %0d", name, stall_cnt_o, m_cnt);
        end
        @(negedge clk_i);
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_i       = 1'b1;
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        addr_i      = '0;
        wdata_i     = '0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({mem_req_o, mem_we_o, stall_o, err_o} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl: got req/we/stall/err=%b%b%b%b, want 0000", mem_req_o, mem_we_o, stall_o, err_o);
        end
        checks++;
        if (mem_addr_o !== '0 || mem_wdata_o !== '0 || rdata_o !== '0) begin
            failures++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h, want zeros", mem_addr_o, mem_wdata_o, rdata_o);
        end
        checks++;
        if (stall_cnt_o !== '0) begin
            failures++;
            $display("FAIL reset_cnt: got %0d, want 0", stall_cnt_o);
        end
        rst_i   = 1'b0;
        m_rdata = '0;
        m_err   = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic test_read;
        do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 3, "read");
    endtask

    task automatic test_write;
        do_access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h5555_5555, 1, "write");
    endtask

    task automatic test_back_to_back;
        do_access(1'b1, 1'b0, 32'h0000_0030, 32'h0, 32'h0BEE_F00D, 2, "b2b_read");
        do_access(1'b0, 1'b1, 32'h0000_0034, 32'hA1B2_C3D4, 32'h0, 1, "b2b_write");
    endtask

    task automatic test_ack_at_limit;
        do_access(1'b1, 1'b0, 32'h0000_0038, 32'h0, 32'h1357_9BDF, WMAX, "ack_at_limit");
    endtask

    task automatic test_timeout;
        do_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 0, "timeout");
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        #1;
        checks++;
        if (stall_o !== 1'b0 || mem_req_o !== 1'b0 || rdata_o !== m_rdata || err_o !== 1'b1 ||
            stall_cnt_o !== 32'(m_cnt)) begin
            failures++;
            $display("FAIL late_ack: got stall=%b req=%b rdata=%h err=%b cnt=%0d, want 0 0 %h 1 %0d",
                     stall_o, mem_req_o, rdata_o, err_o, stall_cnt_o, m_rdata, m_cnt);
        end
        @(negedge clk_i);
        do_access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 32'h2468_ACE0, 2, "err_sticky");
    endtask

    task automatic test_reset_mid_busy;
        MemRead_i = 1'b1;
        addr_i    = 32'h0000_0080;
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        checks++;
        if (mem_req_o !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy_req: got %b, want 1", mem_req_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_drop: got req=%b stall=%b, want 0 0", mem_req_o, stall_o);
        end
        checks++;
        if (err_o !== 1'b0 || stall_cnt_o !== '0) begin
            failures++;
            $display("FAIL rst_clear: got err=%b cnt=%0d, want 0 0", err_o, stall_cnt_o);
        end
        m_rdata   = '0;
        m_err     = 1'b0;
        m_cnt     = 0;
        MemRead_i = 1'b0;
        @(negedge clk_i);
        rst_i       = 1'b0;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h1111_1111;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || rdata_o !== '0 || stall_cnt_o !== '0) begin
            failures++;
            $display("FAIL stale_ack: got req=%b stall=%b rdata=%h cnt=%0d, want 0 0 0 0",
                     mem_req_o, stall_o, rdata_o, stall_cnt_o);
        end
        @(negedge clk_i);
        do_access(1'b1, 1'b0, 32'h0000_0084, 32'h0, 32'hA5A5_A5A5, 2, "post_reset_read");
    endtask

    task automatic test_both_high;
        do_access(1'b1, 1'b1, 32'h0000_00C0, 32'h0BAD_F00D, 32'h7777_7777, 2, "both_high");
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h9999_9999;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        #1;
        checks++;
        if (stall_o !== 1'b0 || mem_req_o !== 1'b0 || rdata_o !== m_rdata || stall_cnt_o !== 32'(m_cnt)) begin
            failures++;
            $display("FAIL idle_ack: got stall=%b req=%b rdata=%h cnt=%0d, want 0 0 %h %0d",
                     stall_o, mem_req_o, rdata_o, stall_cnt_o, m_rdata, m_cnt);
        end
    endtask

    task automatic test_saturation;
        logic [2:0] exp_sat;
        exp_sat = (m_cnt > 7) ? 3'd7 : 3'(m_cnt);
        checks++;
        if (s_cnt !== exp_sat) begin
            failures++;
            $display("FAIL sat_cnt: got %0d, want %0d", s_cnt, exp_sat);
        end
        checks++;
        if (s_rdata !== m_rdata || s_err !== m_err || s_req !== 1'b0 || s_stall !== 1'b0 ||
            s_we !== 1'b1 || s_addr !== 32'h0000_00C0 || s_wdata !== 32'h0BAD_F00D) begin
            failures++;
            $display("FAIL sat_state: got rdata=%h err=%b req=%b stall=%b we=%b addr=%h wdata=%h, want %h %b 0 0 1 000000c0 0badf00d",
                     s_rdata, s_err, s_req, s_stall, s_we, s_addr, s_wdata, m_rdata, m_err);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_ack_at_limit();
        test_timeout();
        test_reset_mid_busy();
        test_both_high();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
